fifo_rd_ctrl: RTL and testbench

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_rd_ctrl.sv | 74 +++++++
 tb/tb_fifo_rd_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an async FIFO: Gray write-pointer sync, read pointer,
// registered empty / almost-empty / fill-level flags and a sticky underflow flag.
module fifo_rd_ctrl #(
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AEMPTY_TH   = 1
) (
    input  logic              R_CLK,
    input  logic              R_RST,
    input  logic              R_INC,
    input  logic [ADDR_W:0]   wptr_gray,
    input  logic              R_UF_CLR,
    output logic [ADDR_W-1:0] raddr,
    output logic [ADDR_W:0]   rptr,
    output logic              rempty,
    output logic              raempty,
    output logic [ADDR_W:0]   rcount,
    output logic              r_underflow
);
    localparam int              PW    = ADDR_W + 1;
    localparam logic [ADDR_W:0] AE_TH = PW'(AEMPTY_TH);

    logic [SYNC_STAGES-1:0][ADDR_W:0] sync_q;
    logic [ADDR_W:0] rq_wptr, wbin_s;
    logic [ADDR_W:0] rbin_q, rbin_d, rgray_d, cnt_d;
    logic [ADDR_W:0] rptr_q, rcount_q;
    logic            rempty_q, raempty_q, uf_q, uf_d;
    logic            rd_ok, uf_set;

    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], wptr_gray};
    end
    assign rq_wptr = sync_q[SYNC_STAGES-1];

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        wbin_s = '0;
        for (int i = 0; i <= ADDR_W; i++) wbin_s[i] = ^(rq_wptr >> i);
    end

    assign rd_ok   = R_INC & ~rempty_q;
    assign uf_set  = R_INC & rempty_q;
    assign rbin_d  = rbin_q + {{ADDR_W{1'b0}}, rd_ok};
    assign rgray_d = rbin_d ^ (rbin_d >> 1);
    assign cnt_d   = wbin_s - rbin_d;
    assign uf_d    = uf_set ? 1'b1 : (R_UF_CLR ? 1'b0 : uf_q);

    // Flags are computed from the post-pop pointer so empty lands on the popping edge
    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            rbin_q    <= '0;
            rptr_q    <= '0;
            rempty_q  <= 1'b1;
            raempty_q <= 1'b1;
            rcount_q  <= '0;
            uf_q      <= 1'b0;
        end else begin
            rbin_q    <= rbin_d;
            rptr_q    <= rgray_d;
            rempty_q  <= (rgray_d == rq_wptr);
            raempty_q <= (cnt_d <= AE_TH);
            rcount_q  <= cnt_d;
            uf_q      <= uf_d;
        end
    end

    assign raddr       = rbin_q[ADDR_W-1:0];
    assign rptr        = rptr_q;
    assign rempty      = rempty_q;
    assign raempty     = raempty_q;
    assign rcount      = rcount_q;
    assign r_underflow = uf_q;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: writes/reads tracked as running totals,
// write totals become visible after the synchronizer delay.
module tb_fifo_rd_ctrl;
    localparam int AW = 3, SS = 2, TH = 1, DEPTH = 8, PW = 16;

    logic          R_CLK = 0, R_RST = 0, R_INC = 0, R_UF_CLR = 0;
    logic [AW:0]   wptr_gray = '0;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr, rcount;
    logic          rempty, raempty, r_underflow;

    typedef struct { int raddr; int rptr; int rempty; int raempty; int rcount; int uf; } exp_t;
    exp_t expq[$];

    int n_tests = 0, n_fail = 0;
    int W, R;
    int whist[$];
    bit m_empty, m_uf;

    fifo_rd_ctrl #(.ADDR_W(AW), .SYNC_STAGES(SS), .AEMPTY_TH(TH)) dut (
        .R_CLK(R_CLK), .R_RST(R_RST), .R_INC(R_INC), .wptr_gray(wptr_gray),
        .R_UF_CLR(R_UF_CLR), .raddr(raddr), .rptr(rptr), .rempty(rempty),
        .raempty(raempty), .rcount(rcount), .r_underflow(r_underflow)
    );

    always #5 R_CLK = ~R_CLK;

    function automatic int gray(int b);
        int m = b % PW;
        return m ^ (m >> 1);
    endfunction

    task automatic cmp(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset(string tag);
        cmp({tag, ".rempty"}, rempty, 1);
        cmp({tag, ".raempty"}, raempty, 1);
        cmp({tag, ".rcount"}, rcount, 0);
        cmp({tag, ".rptr"}, rptr, 0);
        cmp({tag, ".raddr"}, raddr, 0);
        cmp({tag, ".uf"}, r_underflow, 0);
    endtask

    task automatic model_reset();
        W = 0; R = 0; m_empty = 1; m_uf = 0;
        whist.delete();
        for (int i = 0; i <= SS; i++) whist.push_back(0);
    endtask

    // One read-domain cycle: drive inputs, predict the state after the next edge
    task automatic step(bit inc, bit clr, bit wr);
        exp_t e;
        int   vis, cnt;
        bit   nuf;
        @(negedge R_CLK);
        if (wr) W++;
        R_INC = inc; R_UF_CLR = clr; wptr_gray = 4'(gray(W));
        nuf = (inc && m_empty) ? 1'b1 : (clr ? 1'b0 : m_uf);
        if (inc && !m_empty) R++;
        whist.push_front(W);
        vis = whist[SS];
        whist.pop_back();
        cnt = vis - R;
        e.raddr = R % DEPTH; e.rptr = gray(R); e.rcount = cnt;
        e.rempty = (cnt == 0); e.raempty = (cnt <= TH); e.uf = nuf;
        m_empty = (cnt == 0); m_uf = nuf;
        expq.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge R_CLK); #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                cmp("raddr", raddr, e.raddr);
                cmp("rptr", rptr, e.rptr);
                cmp("rempty", rempty, e.rempty);
                cmp("raempty", raempty, e.raempty);
                cmp("rcount", rcount, e.rcount);
                cmp("r_underflow", r_underflow, e.uf);
                if (rcount > DEPTH) cmp("rcount_le_depth", rcount, DEPTH);
            end
        end
    end

    initial begin : stim
        int guard;
        model_reset();
        wptr_gray = 4'b0101;
        #12 chk_reset("rst");
        @(negedge R_CLK); wptr_gray = '0; R_RST = 1;

        // Three entries appear, then three pops drain the FIFO
        step(0, 0, 0); step(0, 0, 0);
        W = 3; step(0, 0, 0);
        repeat (3) step(0, 0, 0);
        repeat (3) step(1, 0, 0);

        // Underflow: set, set wins over clear, clear alone
        step(1, 0, 0); step(1, 1, 0); step(0, 1, 0); step(0, 0, 0);

        // Random interleaved traffic, many pointer laps
        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0,
                 (W - R < DEPTH) && ($urandom_range(0, 1) == 1));

        // Drain, underflow, then fill to 5 and reset asynchronously mid-cycle
        repeat (SS + 1) step(0, 0, 0);
        guard = 0;
        while (!m_empty && guard < 20) begin step(1, 0, 0); guard++; end
        cmp("drain_bound", m_empty, 1);
        step(1, 0, 0);
        repeat (5) step(0, 0, 1);
        repeat (SS + 1) step(0, 0, 0);
        @(posedge R_CLK); #3;
        R_RST = 0; R_INC = 0; R_UF_CLR = 0; wptr_gray = '0;
        #1 chk_reset("midrst");
        @(negedge R_CLK); #1 chk_reset("midrst_hold");
        @(negedge R_CLK); R_RST = 1;
        model_reset();

        step(0, 0, 1); step(0, 0, 1);
        repeat (SS + 1) step(0, 0, 0);
        step(1, 0, 0); step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);

        repeat (2) @(posedge R_CLK);
        #3 cmp("scoreboard_drained", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
